ser_par_conv_p: RTL and testbench

SER_PAR_CONV_P -- requirements
Module: ser_par_conv_p

---
 rtl/ser_par_conv_p.sv | 123 ++++++++++++
 tb/tb_ser_par_conv_p.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ser_par_conv_p.sv
// Serial-to-parallel converter: gathers WIDTH serial bits into a word and offers
// it downstream with a valid/ready handshake, flagging words dropped while the
// output register is still occupied.
module ser_par_conv_p #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       din,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       ready,
  output logic [WIDTH-1:0]           data_out,
  output logic                       valid,
  output logic                       overrun,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
  output logic                       dbg_state
);

  // Handshake: a word transfers at a rising edge where valid=1 and ready=1;
  // valid never drops without a transfer, and ready is ignored while valid=0.

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] sr, sr_nxt;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] data_nxt;
  logic             valid_nxt, overrun_nxt;
  logic             accept, complete, load, drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      sr       <= '0;
      data_out <= '0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= cnt_nxt;
      sr       <= sr_nxt;
      data_out <= data_nxt;
      valid    <= valid_nxt;
      overrun  <= overrun_nxt;
    end
  end

  // The completed word is the shift register with the final bit already folded
  // in, so it can be loaded at the same edge that accepts that bit.
  always_comb begin
    if (MSB_FIRST) shifted = {sr[WIDTH-2:0], din};
    else           shifted = {din, sr[WIDTH-1:1]};
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    sr_nxt    = sr;
    accept    = en && !flush;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (flush) begin
          sr_nxt  = '0;
          cnt_nxt = '0;
        end else if (accept) begin
          state_nxt = SHIFT;
          cnt_nxt   = CW'(1);
          sr_nxt    = shifted;
        end
      end
      SHIFT: begin
        if (flush) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          sr_nxt    = '0;
        end else if (accept) begin
          if (bit_cnt == LAST) begin
            complete  = 1'b1;
            state_nxt = IDLE;
            cnt_nxt   = '0;
            sr_nxt    = '0;
          end else begin
            cnt_nxt = bit_cnt + CW'(1);
            sr_nxt  = shifted;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        sr_nxt    = '0;
      end
    endcase
  end

  // Output register: a completed word replaces data_out only if the slot is
  // empty or being consumed this cycle; otherwise it is lost and recorded.
  always_comb begin
    load        = complete && (!valid || ready);
    drop        = complete && valid && !ready;
    data_nxt    = load ? shifted : data_out;
    valid_nxt   = valid;
    overrun_nxt = overrun;
    if (load)                valid_nxt = 1'b1;
    else if (valid && ready) valid_nxt = 1'b0;
    if (flush)               overrun_nxt = 1'b0;
    else if (drop)           overrun_nxt = 1'b1;
  end

  assign dbg_state = (state == SHIFT);

endmodule

// File: tb/tb_ser_par_conv_p.sv
// Directed bench for ser_par_conv_p: table-driven vectors on an 8-bit LSB-first
// instance, an MSB-first twin, and a 32-bit instance for the reset-mid-word case.
module tb_ser_par_conv_p;

  logic clk = 1'b0;
  logic rst_n, din, en, flush, ready;

  logic [7:0]  d8, d8m;
  logic [31:0] d32;
  logic        v8, v8m, v32, o8, o8m, o32, s8, s8m, s32;
  logic [3:0]  c8, c8m;
  logic [5:0]  c32;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic       din, en, flush, ready;
    logic [7:0] d;
    logic       v, o;
    logic [3:0] c;
  } vec_t;

  vec_t vecs[$];

  ser_par_conv_p #(.WIDTH(8), .MSB_FIRST(1'b0)) u8 (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en), .flush(flush), .ready(ready),
    .data_out(d8), .valid(v8), .overrun(o8), .bit_cnt(c8), .dbg_state(s8));

  ser_par_conv_p #(.WIDTH(8), .MSB_FIRST(1'b1)) u8m (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en), .flush(flush), .ready(ready),
    .data_out(d8m), .valid(v8m), .overrun(o8m), .bit_cnt(c8m), .dbg_state(s8m));

  ser_par_conv_p #(.WIDTH(32), .MSB_FIRST(1'b0)) u32 (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en), .flush(flush), .ready(ready),
    .data_out(d32), .valid(v32), .overrun(o32), .bit_cnt(c32), .dbg_state(s32));

  // clock / reset
  always #5 clk = ~clk;

  // driver helpers
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic i_din, input logic i_en, input logic i_fl,
                              input logic i_rdy, input logic [7:0] e_d, input logic e_v,
                              input logic e_o, input logic [3:0] e_c);
    vec_t t;
    t.din = i_din; t.en = i_en; t.flush = i_fl; t.ready = i_rdy;
    t.d = e_d; t.v = e_v; t.o = e_o; t.c = e_c;
    vecs.push_back(t);
  endfunction

  task automatic add_word(input logic [7:0] w, input logic rdy_last,
                          input logic [7:0] d_before, input logic v_before,
                          input logic [7:0] d_after, input logic v_after, input logic o_after);
    for (int b = 0; b < 7; b++)
      add(w[b], 1'b1, 1'b0, 1'b0 | (rdy_last & 1'b0), d_before, v_before, 1'b0, 4'(b + 1));
    add(w[7], 1'b1, 1'b0, rdy_last, d_after, v_after, o_after, 4'd0);
  endtask

  initial begin
    int acc;
    int budget;
    logic [31:0] word;
    logic [31:0] exp_w;

    rst_n = 1'b0; din = 1'b0; en = 1'b0; flush = 1'b0; ready = 1'b0;

    // Word 0x8D LSB-first, ready high throughout: loads on the 8th edge.
    for (int b = 0; b < 7; b++) begin
      logic [7:0] w8d;
      w8d = 8'h8D;
      add(w8d[b], 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'(b + 1));
    end
    add(1'b1, 1'b1, 1'b0, 1'b1, 8'h8D, 1'b1, 1'b0, 4'd0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 8'h8D, 1'b1, 1'b0, 4'd0);
    // Word 0x55 with ready low and an en=0 hold mid-word: dropped, overrun set.
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'h8D, 1'b1, 1'b0, 4'd1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'h8D, 1'b1, 1'b0, 4'd2);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'h8D, 1'b1, 1'b0, 4'd3);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'h8D, 1'b1, 1'b0, 4'd4);
    add(1'b1, 1'b0, 1'b0, 1'b0, 8'h8D, 1'b1, 1'b0, 4'd4);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'h8D, 1'b1, 1'b0, 4'd5);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'h8D, 1'b1, 1'b0, 4'd6);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'h8D, 1'b1, 1'b0, 4'd7);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'h8D, 1'b1, 1'b1, 4'd0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h8D, 1'b1, 1'b0, 4'd0);
    // Word 0x3C, ready only on the completing edge: replaces 0x8D, valid stays.
    add_word(8'h3C, 1'b1, 8'h8D, 1'b1, 8'h3C, 1'b1, 1'b0);
    // Four bits then flush together with en: partial word and bit discarded.
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 4'd1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 4'd2);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 4'd3);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 4'd4);
    add(1'b1, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 4'd0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 4'd0);
    add_word(8'hA7, 1'b0, 8'h3C, 1'b0, 8'hA7, 1'b1, 1'b0);
    // Flush alongside a handshake: valid still clears, data_out kept.
    add(1'b0, 1'b0, 1'b1, 1'b1, 8'hA7, 1'b0, 1'b0, 4'd0);

    // Reset values, sampled while reset is held.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data8", {56'd0, d8}, 64'h0);
    chk("rst_valid8", {63'd0, v8}, 64'h0);
    chk("rst_ovr8", {63'd0, o8}, 64'h0);
    chk("rst_cnt8", {60'd0, c8}, 64'h0);
    chk("rst_data32", {32'd0, d32}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      din = vecs[i].din; en = vecs[i].en; flush = vecs[i].flush; ready = vecs[i].ready;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_data", i), {56'd0, d8}, {56'd0, vecs[i].d});
      chk($sformatf("vec%0d_valid", i), {63'd0, v8}, {63'd0, vecs[i].v});
      chk($sformatf("vec%0d_ovr", i), {63'd0, o8}, {63'd0, vecs[i].o});
      chk($sformatf("vec%0d_cnt", i), {60'd0, c8}, {60'd0, vecs[i].c});
      if (i == 7) begin
        chk("msb_first_data", {56'd0, d8m}, 64'hB1);
        chk("msb_first_valid", {63'd0, v8m}, 64'h1);
      end
      @(negedge clk);
    end
    en = 1'b0; flush = 1'b0; ready = 1'b0;

    // Reset mid-word on the 32-bit instance after 17 accepted bits.
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    acc = 0;
    budget = 0;
    while (acc < 17 && budget < 500) begin
      en = 1'($urandom_range(0, 1));
      din = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      if (en) acc++;
      budget++;
      chk("w32_cnt_pre", {58'd0, c32}, 64'(acc));
      @(negedge clk);
    end
    if (acc < 17) chk("w32_pre_budget", 64'(acc), 64'd17);
    en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_cnt32", {58'd0, c32}, 64'h0);
    chk("async_rst_data32", {32'd0, d32}, 64'h0);
    chk("async_rst_valid32", {63'd0, v32}, 64'h0);
    chk("async_rst_ovr32", {63'd0, o32}, 64'h0);
    chk("async_rst_data8", {56'd0, d8}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    word = '0;
    acc = 0;
    budget = 0;
    while (acc < 32 && budget < 2000) begin
      en = 1'($urandom_range(0, 1));
      din = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      if (en) begin
        word[acc] = din;
        acc++;
        if (acc == 32) exp_q.push_back(word);
      end
      budget++;
      chk("w32_cnt", {58'd0, c32}, 64'(acc % 32));
      @(negedge clk);
    end
    en = 1'b0;
    if (exp_q.size() == 0) begin
      chk("w32_budget", 64'(acc), 64'd32);
    end else begin
      exp_w = exp_q.pop_front();
      chk("w32_data", {32'd0, d32}, {32'd0, exp_w});
      chk("w32_valid", {63'd0, v32}, 64'h1);
      chk("w32_ovr", {63'd0, o32}, 64'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
